rpn_evaluator: RTL and testbench

RPN_EVALUATOR -- requirements
Module: rpn_evaluator

---
 rtl/rpn_pkg.sv | 25 ++
 rtl/rpn_alu.sv | 24 ++
 rtl/rpn_evaluator.sv | 129 ++++++++++++
 tb/tb_rpn_evaluator.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rpn_pkg.sv
// Shared encodings for the RPN evaluator: token types, operator codes, FSM states.
package rpn_pkg;

    localparam logic [1:0] TOK_OPERAND  = 2'b00;
    localparam logic [1:0] TOK_OPERATOR = 2'b01;
    localparam logic [1:0] TOK_END      = 2'b10;
    localparam logic [1:0] TOK_IGNORE   = 2'b11;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PUSH    = 3'd1,
        S_POP_B   = 3'd2,
        S_POP_A   = 3'd3,
        S_EXEC    = 3'd4,
        S_RES_POP = 3'd5,
        S_DRAIN   = 3'd6,
        S_OUT     = 3'd7
    } state_t;

endpackage

// File: rtl/rpn_alu.sv
// Combinational arithmetic unit: y = a op b, wrapped to WIDTH bits.
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_MUL:  y = a * b;
            OP_AND:  y = a & b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/rpn_evaluator.sv
// Token-driven RPN expression evaluator that keeps its operands on an external stack.
module rpn_evaluator
    import rpn_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tok_valid,
    output logic             tok_ready,
    input  logic [1:0]       tok_type,
    input  logic [1:0]       tok_op,
    input  logic [WIDTH-1:0] tok_data,
    output logic             stk_push,
    output logic             stk_pop,
    output logic [WIDTH-1:0] stk_din,
    input  logic [WIDTH-1:0] stk_dout,
    input  logic             stk_empty,
    input  logic             stk_full,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err
);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] hold_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [1:0]       op_reg;
    logic             err_reg;
    logic [WIDTH-1:0] alu_y;

    rpn_alu #(.WIDTH(WIDTH)) u_alu (
        .a  (a_reg),
        .b  (b_reg),
        .op (op_reg),
        .y  (alu_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (tok_valid) begin
                    case (tok_type)
                        TOK_OPERAND:  state_next = S_PUSH;
                        TOK_OPERATOR: state_next = S_POP_B;
                        TOK_END:      state_next = S_RES_POP;
                        default:      state_next = S_IDLE;
                    endcase
                end
            end
            S_PUSH:    state_next = S_IDLE;
            S_POP_B:   state_next = stk_empty ? S_IDLE : S_POP_A;
            S_POP_A:   state_next = stk_empty ? S_IDLE : S_EXEC;
            S_EXEC:    state_next = S_PUSH;
            S_RES_POP: state_next = stk_empty ? S_OUT : S_DRAIN;
            S_DRAIN:   state_next = stk_empty ? S_OUT : S_DRAIN;
            S_OUT:     state_next = res_ready ? S_IDLE : S_OUT;
            default:   state_next = S_IDLE;
        endcase
    end

    // Datapath: every stack underflow/overflow or leftover operand sets the sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_reg <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            op_reg   <= '0;
            err_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (tok_valid && tok_type == TOK_OPERAND)  hold_reg <= tok_data;
                    if (tok_valid && tok_type == TOK_OPERATOR) op_reg   <= tok_op;
                end
                S_PUSH: begin
                    if (stk_full) err_reg <= 1'b1;
                end
                S_POP_B: begin
                    if (stk_empty) err_reg <= 1'b1;
                    else           b_reg   <= stk_dout;
                end
                S_POP_A: begin
                    if (stk_empty) err_reg <= 1'b1;
                    else           a_reg   <= stk_dout;
                end
                S_EXEC: hold_reg <= alu_y;
                S_RES_POP: begin
                    if (stk_empty) begin
                        err_reg  <= 1'b1;
                        hold_reg <= '0;
                    end else begin
                        hold_reg <= stk_dout;
                    end
                end
                S_DRAIN: begin
                    if (!stk_empty) err_reg <= 1'b1;
                end
                S_OUT: begin
                    if (res_ready) begin
                        err_reg  <= 1'b0;
                        hold_reg <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        tok_ready = (state_reg == S_IDLE) && !rst;
        stk_push  = (state_reg == S_PUSH) && !stk_full;
        stk_din   = stk_push ? hold_reg : '0;
        stk_pop   = ((state_reg == S_POP_B) || (state_reg == S_POP_A) ||
                     (state_reg == S_RES_POP) || (state_reg == S_DRAIN)) && !stk_empty;
        res_valid = (state_reg == S_OUT);
        res_err   = res_valid && err_reg;
        res_data  = (res_valid && !err_reg) ? hold_reg : '0;
    end

endmodule

// File: tb/tb_rpn_evaluator.sv
// Bench for rpn_evaluator: external DEPTH-16 stack, queue-based RPN reference, directed plus random expressions.
module tb_rpn_evaluator;

    localparam int W     = 32;
    localparam int DEPTH = 16;

    logic          clk = 0;
    logic          rst = 1;
    logic          tok_valid = 0;
    logic          tok_ready;
    logic [1:0]    tok_type = 0;
    logic [1:0]    tok_op = 0;
    logic [W-1:0]  tok_data = 0;
    logic          stk_push, stk_pop;
    logic [W-1:0]  stk_din, stk_dout;
    logic          stk_empty, stk_full;
    logic          res_valid;
    logic          res_ready = 0;
    logic [W-1:0]  res_data;
    logic          res_err;

    int compared   = 0;
    int mismatched = 0;
    bit done = 0;

    always #5 clk = ~clk;

    rpn_evaluator #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .tok_valid(tok_valid), .tok_ready(tok_ready),
        .tok_type(tok_type), .tok_op(tok_op), .tok_data(tok_data),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din),
        .stk_dout(stk_dout), .stk_empty(stk_empty), .stk_full(stk_full),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_err(res_err)
    );

    // External stack
    logic [W-1:0] mem [DEPTH];
    int cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) cnt <= 0;
        else if (stk_push && cnt < DEPTH) begin
            mem[cnt] <= stk_din;
            cnt <= cnt + 1;
        end else if (stk_pop && cnt > 0) cnt <= cnt - 1;
    end
    assign stk_empty = (cnt == 0);
    assign stk_full  = (cnt == DEPTH);
    assign stk_dout  = (stk_pop && cnt > 0) ? mem[cnt-1] : '0;

    task automatic check(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && !done) begin
            check("push_pop_excl", W'(stk_push & stk_pop), '0);
            check("pop_when_empty", W'(stk_pop & stk_empty), '0);
            check("push_when_full", W'(stk_push & stk_full), '0);
        end
    end

    typedef struct {
        logic [1:0]   t;
        logic [1:0]   op;
        logic [W-1:0] d;
    } tok_t;
    tok_t prog[$];

    function automatic logic [W-1:0] apply(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a * b;
            default: return a & b;
        endcase
    endfunction

    // Reference: plain RPN evaluation over a bounded queue.
    task automatic model(output logic [W-1:0] data, output logic err);
        logic [W-1:0] st[$];
        logic [W-1:0] a, b, r;
        err = 0;
        foreach (prog[i]) begin
            case (prog[i].t)
                2'd0: if (st.size() < DEPTH) st.push_back(prog[i].d); else err = 1;
                2'd1: begin
                    if (st.size() == 0) err = 1;
                    else begin
                        b = st.pop_back();
                        if (st.size() == 0) err = 1;
                        else begin
                            a = st.pop_back();
                            st.push_back(apply(prog[i].op, a, b));
                        end
                    end
                end
                default: ;
            endcase
        end
        if (st.size() == 0) begin
            err = 1;
            r = 0;
        end else begin
            r = st.pop_back();
            if (st.size() != 0) err = 1;
        end
        data = err ? '0 : r;
    endtask

    task automatic send(logic [1:0] t, logic [1:0] op, logic [W-1:0] d);
        int n = 0;
        @(negedge clk);
        tok_valid = 1; tok_type = t; tok_op = op; tok_data = d;
        while (!tok_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!tok_ready) check("tok_ready_timeout", W'(tok_ready), W'(1));
        @(posedge clk);
        #1 tok_valid = 0;
    endtask

    task automatic get_result(string tag, logic [W-1:0] exp_d, logic exp_e, int hold);
        int n = 0;
        @(negedge clk);
        while (!res_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".res_valid"}, W'(res_valid), W'(1));
        check({tag, ".res_data"}, res_data, exp_d);
        check({tag, ".res_err"}, W'(res_err), W'(exp_e));
        $display("%s: res_data=%h res_err=%0d (expected %h/%0d)", tag, res_data, res_err, exp_d, exp_e);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check({tag, ".hold_valid"}, W'(res_valid), W'(1));
            check({tag, ".hold_data"}, res_data, exp_d);
            check({tag, ".hold_tok_ready"}, W'(tok_ready), W'(0));
        end
        res_ready = 1;
        @(posedge clk);
        #1 res_ready = 0;
        @(negedge clk);
        check({tag, ".stack_empty_after"}, W'(cnt), W'(0));
        check({tag, ".valid_dropped"}, W'(res_valid), W'(0));
    endtask

    task automatic run_expr(string tag, int hold);
        logic [W-1:0] ed;
        logic ee;
        model(ed, ee);
        foreach (prog[i]) send(prog[i].t, prog[i].op, prog[i].d);
        send(2'd2, 2'd0, '0);
        get_result(tag, ed, ee, hold);
    endtask

    function automatic tok_t num(logic [W-1:0] v);
        tok_t x; x.t = 2'd0; x.op = 2'd0; x.d = v; return x;
    endfunction
    function automatic tok_t opr(logic [1:0] o);
        tok_t x; x.t = 2'd1; x.op = o; x.d = '0; return x;
    endfunction

    initial begin
        // Reset state
        #2;
        check("rst.tok_ready", W'(tok_ready), '0);
        check("rst.stk_push", W'(stk_push), '0);
        check("rst.stk_pop", W'(stk_pop), '0);
        check("rst.stk_din", stk_din, '0);
        check("rst.res_valid", W'(res_valid), '0);
        check("rst.res_data", res_data, '0);
        check("rst.res_err", W'(res_err), '0);
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        check("post_rst.tok_ready", W'(tok_ready), W'(1));

        // 3 4 add: also observe the push one cycle after the operand is accepted
        send(2'd0, 2'd0, 32'd3);
        check("operand_push_strobe", W'(stk_push), W'(1));
        check("operand_push_data", stk_din, 32'd3);
        prog = '{num(4), opr(2'd0)};
        foreach (prog[i]) send(prog[i].t, prog[i].op, prog[i].d);
        send(2'd2, 2'd0, '0);
        get_result("add_3_4", 32'd7, 1'b0, 0);

        prog = '{num(10), num(3), opr(2'd1), num(2), opr(2'd2)};
        run_expr("sub_mul", 0);
        prog = '{num(32'hFFFF_FFFF), num(2), opr(2'd0)};
        run_expr("add_wrap", 0);
        prog = '{num(5), opr(2'd0)};
        run_expr("underflow_pop_a", 0);
        prog = '{num(1), num(1), opr(2'd0)};
        run_expr("after_err", 0);
        prog.delete();
        for (int i = 0; i < 17; i++) prog.push_back(num(W'(i + 1)));
        run_expr("overflow_17", 0);
        prog = '{num(1), num(2)};
        run_expr("leftover_hold5", 5);
        prog = '{num(32'hF0F0_1234), num(32'h0FF0_FFFF), opr(2'd3)};
        run_expr("and_op", 1);
        prog.delete();
        run_expr("empty_expr", 0);

        // Reset while the evaluator sits in POP_A
        send(2'd0, 2'd0, 32'd1);
        send(2'd0, 2'd0, 32'd2);
        send(2'd1, 2'd0, '0);          // returns 1 ns into POP_B
        @(posedge clk);                // now in POP_A
        #1 rst = 1;
        #1;
        check("midrst.tok_ready", W'(tok_ready), '0);
        check("midrst.stk_pop", W'(stk_pop), '0);
        check("midrst.stk_push", W'(stk_push), '0);
        check("midrst.stk_din", stk_din, '0);
        check("midrst.res_valid", W'(res_valid), '0);
        check("midrst.res_data", res_data, '0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        check("midrst.tok_ready_after", W'(tok_ready), W'(1));
        prog = '{num(6), num(7), opr(2'd2)};
        run_expr("after_midrst", 0);

        // Random expressions, including ignored tokens and near-full stacks
        for (int e = 0; e < 40; e++) begin
            int len;
            prog.delete();
            len = (e % 8 == 7) ? int'($urandom_range(14, 18)) : int'($urandom_range(1, 9));
            for (int i = 0; i < len; i++) begin
                tok_t x;
                int r = int'($urandom_range(0, 9));
                x.op = 2'($urandom_range(0, 3));
                x.d  = (r == 0) ? 32'hFFFF_FFFF : $urandom;
                x.t  = (e % 8 == 7 || r < 5) ? 2'd0 : (r < 9 ? 2'd1 : 2'd3);
                prog.push_back(x);
            end
            run_expr($sformatf("rand%0d", e), int'($urandom_range(0, 3)));
        end

        done = 1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
